// File: rtl/uart_tx_if.sv
// ---------------------------------------------------------------------------
// uart_tx_if
//   Handshake bundle between a word producer and the UART transmitter.
//   Ports / signals:
//     tx_valid  producer -> tx   request to send tx_data
//     tx_data   producer -> tx   word to send (DATA_BIT_COUNT bits)
//     tx_ready  tx -> producer   transmitter idle and able to accept
//     tx_done   tx -> producer   1-cycle pulse when the last stop bit ends
//   Modports: master = word producer, slave = transmitter.
// ---------------------------------------------------------------------------
interface uart_tx_if #(
    parameter int DATA_BIT_COUNT = 8
);
    logic                      tx_valid;
    logic [DATA_BIT_COUNT-1:0] tx_data;
    logic                      tx_ready;
    logic                      tx_done;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  tx_done
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//   Serialises one parallel word per handshake into an asynchronous UART
//   frame: start bit (0), data LSB-first, optional parity, stop bit(s) (1).
//   The line idles high; one frame is in flight at a time.
//   Ports:
//     clk     input   sole clock, all logic on posedge
//     rst     input   asynchronous, active-high reset
//     bus     slave   tx_valid / tx_data / tx_ready / tx_done handshake
//     serial  output  registered UART line, idle 1
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int DATA_BIT_COUNT   = 8,
    parameter int PARITY_BIT_COUNT = 0,
    parameter bit PARITY_ODD       = 1'b0,
    parameter int STOP_BIT_COUNT   = 1,
    parameter int CLK_PER_BIT      = 8
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus,
    output logic     serial
);

    localparam int CLK_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_BIT_COUNT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                    state, state_n;
    logic [CLK_W-1:0]          clock_count, clock_count_n;
    logic [BIT_W-1:0]          bit_count, bit_count_n;
    logic [DATA_BIT_COUNT-1:0] shift_reg, shift_reg_n;
    logic                      parity_bit, parity_bit_n;
    logic                      serial_n;
    logic                      done_q, done_n;
    logic                      bit_end;

    assign bit_end      = (clock_count == CLK_W'(CLK_PER_BIT - 1));
    assign bus.tx_ready = (state == IDLE);
    assign bus.tx_done  = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            clock_count <= '0;
            bit_count   <= '0;
            shift_reg   <= '0;
            parity_bit  <= 1'b0;
            serial      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state       <= state_n;
            clock_count <= clock_count_n;
            bit_count   <= bit_count_n;
            shift_reg   <= shift_reg_n;
            parity_bit  <= parity_bit_n;
            serial      <= serial_n;
            done_q      <= done_n;
        end
    end

    // The value for the next bit period is registered onto serial on the
    // terminal-count edge of the current one, so the line has no comb path.
    // bit_count indexes data bits in DATA and stop bits in STOP.
    // The shift register moves right so shift_reg[0] is always the next bit.
    always_comb begin
        state_n       = state;
        clock_count_n = clock_count;
        bit_count_n   = bit_count;
        shift_reg_n   = shift_reg;
        parity_bit_n  = parity_bit;
        serial_n      = serial;
        done_n        = 1'b0;

        case (state)
            IDLE: begin
                serial_n      = 1'b1;
                clock_count_n = '0;
                bit_count_n   = '0;
                if (bus.tx_valid) begin
                    shift_reg_n  = bus.tx_data;
                    parity_bit_n = (^bus.tx_data) ^ PARITY_ODD;
                    serial_n     = 1'b0;
                    state_n      = START;
                end
            end

            START: begin
                if (bit_end) begin
                    clock_count_n = '0;
                    bit_count_n   = '0;
                    serial_n      = shift_reg[0];
                    shift_reg_n   = shift_reg >> 1;
                    state_n       = DATA;
                end else begin
                    clock_count_n = clock_count + CLK_W'(1);
                end
            end

            DATA: begin
                if (bit_end) begin
                    clock_count_n = '0;
                    if (bit_count == BIT_W'(DATA_BIT_COUNT - 1)) begin
                        bit_count_n = '0;
                        if (PARITY_BIT_COUNT == 1) begin
                            serial_n = parity_bit;
                            state_n  = PARITY;
                        end else begin
                            serial_n = 1'b1;
                            state_n  = STOP;
                        end
                    end else begin
                        bit_count_n = bit_count + BIT_W'(1);
                        serial_n    = shift_reg[0];
                        shift_reg_n = shift_reg >> 1;
                    end
                end else begin
                    clock_count_n = clock_count + CLK_W'(1);
                end
            end

            PARITY: begin
                if (bit_end) begin
                    clock_count_n = '0;
                    bit_count_n   = '0;
                    serial_n      = 1'b1;
                    state_n       = STOP;
                end else begin
                    clock_count_n = clock_count + CLK_W'(1);
                end
            end

            STOP: begin
                serial_n = 1'b1;
                if (bit_end) begin
                    clock_count_n = '0;
                    if (bit_count == BIT_W'(STOP_BIT_COUNT - 1)) begin
                        bit_count_n = '0;
                        done_n      = 1'b1;
                        state_n     = IDLE;
                    end else begin
                        bit_count_n = bit_count + BIT_W'(1);
                    end
                end else begin
                    clock_count_n = clock_count + CLK_W'(1);
                end
            end

            // Unused encodings recover to a quiet idle line.
            default: begin
                state_n       = IDLE;
                serial_n      = 1'b1;
                clock_count_n = '0;
                bit_count_n   = '0;
            end
        endcase
    end

endmodule
